// File: rtl/axi_load_wb_unit_pkg.sv
// Shared encodings for the AXI load writeback unit: load funct3 codes, RRESP values, FSM states.
package axi_load_wb_unit_pkg;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StR,
    StWb
  } state_e;

endpackage

// File: rtl/axi_load_wb_unit_if.sv
// AXI4-Lite read-address / read-data channels used by the load writeback unit.
interface axi_load_wb_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_load_wb_unit_load_extend.sv
// Byte/halfword lane select and sign/zero extension of a 32-bit read word.
module load_extend
  import axi_load_wb_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // Unsupported encodings fall back to a full word.
    case (funct3_i)
      Funct3Lb:  data_o = {{24{byte_sel[7]}}, byte_sel};
      Funct3Lbu: data_o = {24'b0, byte_sel};
      Funct3Lh:  data_o = {{16{half_sel[15]}}, half_sel};
      Funct3Lhu: data_o = {16'b0, half_sel};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/axi_load_wb_unit.sv
// Completes one MA-stage load over AXI4-Lite and writes the extended result through the
// register file's secondary write port.
module axi_load_wb_unit
  import axi_load_wb_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter logic [2:0]  ARPROT = 3'b000
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        req_addr_i,
  input  logic [4:0]         req_rd_i,
  input  logic [2:0]         req_funct3_i,

  axi_load_wb_unit_if.master m_axi,

  output logic               m_axi_reg_we_o,
  output logic [4:0]         m_axi_addr_d_o,
  output logic [31:0]        m_axi_data_d_o,

  output logic               pend_valid_o,
  output logic [4:0]         pend_rd_o,
  output logic               busy_o,
  output logic               err_o,
  output logic               misalign_o
);

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;
  logic [31:0] data_q;
  logic [1:0]  resp_q;
  logic        misalign_q;

  logic        accept;
  logic        req_misaligned;
  logic [31:0] ext_data;

  assign accept = (state_q == StIdle) && req_valid_i;

  always_comb begin
    case (req_funct3_i)
      Funct3Lh, Funct3Lhu: req_misaligned = req_addr_i[0];
      Funct3Lw:            req_misaligned = (req_addr_i[1:0] != 2'b00);
      default:             req_misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid_i && !req_misaligned) state_d = StAr;
      StAr:    if (m_axi.arready) state_d = StR;
      StR:     if (m_axi.rvalid) state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      data_q     <= '0;
      resp_q     <= RespOkay;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept && req_misaligned;
      if (accept) begin
        addr_q   <= req_addr_i;
        rd_q     <= req_rd_i;
        funct3_q <= req_funct3_i;
      end
      if ((state_q == StR) && m_axi.rvalid) begin
        data_q <= m_axi.rdata;
        resp_q <= m_axi.rresp;
      end
    end
  end

  load_extend u_extend (
    .rdata_i  (data_q),
    .lane_i   (addr_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (ext_data)
  );

  always_comb begin
    // Ready is held low while reset is asserted so every output reads 0 in reset.
    req_ready_o    = rst_n && (state_q == StIdle);
    busy_o         = (state_q != StIdle);
    pend_valid_o   = busy_o && (rd_q != 5'd0);
    pend_rd_o      = busy_o ? rd_q : 5'd0;
    misalign_o     = misalign_q;

    m_axi.arprot   = ARPROT;
    m_axi.arvalid  = (state_q == StAr);
    m_axi.araddr   = m_axi.arvalid ? ADDR_W'({addr_q[31:2], 2'b00}) : '0;
    m_axi.rready   = (state_q == StR);

    m_axi_reg_we_o = 1'b0;
    m_axi_addr_d_o = 5'd0;
    m_axi_data_d_o = 32'd0;
    err_o          = 1'b0;
    if (state_q == StWb) begin
      m_axi_reg_we_o = (rd_q != 5'd0);
      m_axi_addr_d_o = rd_q;
      m_axi_data_d_o = (resp_q == RespOkay) ? ext_data : 32'd0;
      err_o          = (resp_q != RespOkay);
    end
  end

endmodule

// File: tb/tb_axi_load_wb_unit.sv
// Directed table-driven bench for axi_load_wb_unit with a small AXI read-slave responder.
module tb_axi_load_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [4:0]  req_rd;
  logic [2:0]  req_funct3;
  logic        reg_we;
  logic [4:0]  addr_d;
  logic [31:0] data_d;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        busy;
  logic        err;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_load_wb_unit_if #(.ADDR_W(32)) m_axi ();

  axi_load_wb_unit #(.ADDR_W(32), .ARPROT(3'b000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_rd_i       (req_rd),
    .req_funct3_i   (req_funct3),
    .m_axi          (m_axi),
    .m_axi_reg_we_o (reg_we),
    .m_axi_addr_d_o (addr_d),
    .m_axi_data_d_o (data_d),
    .pend_valid_o   (pend_valid),
    .pend_rd_o      (pend_rd),
    .busy_o         (busy),
    .err_o          (err),
    .misalign_o     (misalign)
  );

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          ar_dly;
    int          r_dly;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts on a negedge with the unit idle; returns on the negedge where it is idle again.
  task automatic run_load(input vec_t v);
    int          arcnt, rcnt, we_cnt, err_cnt, we_cyc, err_cyc, done_cyc, wb_cyc;
    logic [31:0] we_data;
    logic [4:0]  we_addr;
    logic [31:0] exp_araddr;
    wb_cyc     = 3 + v.ar_dly + v.r_dly;
    exp_araddr = {v.addr[31:2], 2'b00};
    arcnt = 0; rcnt = 0; we_cnt = 0; err_cnt = 0;
    we_cyc = -1; err_cyc = -1; done_cyc = -1;
    we_data = '0; we_addr = '0;
    chk("req_ready_at_issue", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_addr   = v.addr;
    req_rd     = v.rd;
    req_funct3 = v.f3;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (req_ready) begin
        done_cyc = cyc;
      end else begin
        chk("busy_in_flight", 32'(busy), 32'd1);
        chk("pend_valid", 32'(pend_valid), 32'(v.rd != 5'd0));
        chk("pend_rd", 32'(pend_rd), 32'(v.rd));
      end
      if (m_axi.arvalid) begin
        arcnt++;
        chk("araddr_stable", m_axi.araddr, exp_araddr);
        m_axi.arready = (arcnt > v.ar_dly);
      end else begin
        m_axi.arready = 1'b0;
      end
      if (m_axi.rready) begin
        chk("rready_excl_arvalid", 32'(m_axi.arvalid), 32'd0);
        rcnt++;
        m_axi.rvalid = (rcnt > v.r_dly);
        m_axi.rdata  = m_axi.rvalid ? v.rdata : 32'h5A5A_5A5A;
        m_axi.rresp  = m_axi.rvalid ? v.resp : (v.resp ^ 2'b10);
      end else begin
        m_axi.rvalid = 1'b0;
      end
      if (reg_we) begin
        we_cnt++;
        we_cyc  = cyc;
        we_data = data_d;
        we_addr = addr_d;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (cyc != wb_cyc) begin
        chk("data_d_idle", data_d, 32'd0);
        chk("addr_d_idle", 32'(addr_d), 32'd0);
      end
      chk("misalign_quiet", 32'(misalign), 32'd0);
    end
    m_axi.arready = 1'b0;
    m_axi.rvalid  = 1'b0;
    chk("done_cycle", done_cyc, 4 + v.ar_dly + v.r_dly);
    chk("ar_cycles", arcnt, v.ar_dly + 1);
    chk("r_cycles", rcnt, v.r_dly + 1);
    chk("we_count", we_cnt, 32'(v.rd != 5'd0));
    chk("we_cycle", we_cyc, (v.rd != 5'd0) ? wb_cyc : -1);
    chk("we_addr", 32'(we_addr), 32'(v.rd));
    chk("we_data", we_data, v.exp_data);
    chk("err_count", err_cnt, 32'(v.resp != 2'b00));
    chk("err_cycle", err_cyc, (v.resp != 2'b00) ? wb_cyc : -1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, 32'({req_ready, busy, pend_valid, m_axi.arvalid, m_axi.rready, reg_we,
                             err, misalign}), 32'd0);
    chk({name, "_pend_rd"}, 32'(pend_rd), 32'd0);
    chk({name, "_addr_d"}, 32'(addr_d), 32'd0);
    chk({name, "_data_d"}, data_d, 32'd0);
    chk({name, "_araddr"}, m_axi.araddr, 32'd0);
  endtask

  initial begin
    int we_seen;
    int ar_seen;
    vec_t v;

    vecs[0]  = '{32'h4000_0008, 5'd5,  3'b010, 32'hDEAD_BEEF, 2'b00, 0, 0, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h4000_0003, 5'd1,  3'b000, 32'h80FF_0000, 2'b00, 0, 0, 32'hFFFF_FF80};
    vecs[2]  = '{32'h4000_0003, 5'd2,  3'b100, 32'h80FF_0000, 2'b00, 0, 0, 32'h0000_0080};
    vecs[3]  = '{32'h4000_0002, 5'd3,  3'b101, 32'h80FF_0000, 2'b00, 0, 0, 32'h0000_80FF};
    vecs[4]  = '{32'h4000_0002, 5'd4,  3'b001, 32'h80FF_0000, 2'b00, 0, 0, 32'hFFFF_80FF};
    vecs[5]  = '{32'h4000_0001, 5'd6,  3'b000, 32'h1234_5678, 2'b00, 0, 0, 32'h0000_0056};
    vecs[6]  = '{32'h4000_0002, 5'd8,  3'b000, 32'h00A5_0000, 2'b00, 0, 0, 32'hFFFF_FFA5};
    vecs[7]  = '{32'h4000_0000, 5'd10, 3'b001, 32'h1234_F00D, 2'b00, 0, 0, 32'hFFFF_F00D};
    vecs[8]  = '{32'h4000_0000, 5'd11, 3'b101, 32'h1234_F00D, 2'b00, 0, 0, 32'h0000_F00D};
    vecs[9]  = '{32'h4000_0004, 5'd12, 3'b011, 32'hCAFE_F00D, 2'b00, 0, 0, 32'hCAFE_F00D};
    vecs[10] = '{32'h4000_000C, 5'd13, 3'b010, 32'hA5A5_0001, 2'b00, 4, 3, 32'hA5A5_0001};
    vecs[11] = '{32'h4000_0010, 5'd7,  3'b010, 32'h1234_5678, 2'b10, 0, 0, 32'h0000_0000};
    vecs[12] = '{32'h4000_0011, 5'd0,  3'b000, 32'h1234_5678, 2'b10, 0, 0, 32'h0000_0000};
    vecs[13] = '{32'h4000_0014, 5'd0,  3'b010, 32'h1111_1111, 2'b00, 0, 0, 32'h0000_0000};
    vecs[14] = '{32'h4000_0000, 5'd31, 3'b100, 32'h0000_00FF, 2'b00, 2, 0, 32'h0000_00FF};

    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_rd = '0; req_funct3 = '0;
    m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rresp = 2'b00;
    #1;
    chk_all_zero("reset");
    chk("arprot", 32'(m_axi.arprot), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    chk("busy_after_reset", 32'(busy), 32'd0);

    // Back-to-back table: each load issues on the cycle its predecessor returns to idle.
    foreach (vecs[i]) run_load(vecs[i]);

    // Misaligned LW, then misaligned LHU: pulse only, no bus traffic, no write.
    req_valid = 1'b1; req_addr = 32'h4000_0006; req_rd = 5'd3; req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("misalign_pulse_lw", 32'(misalign), 32'd1);
    chk("misalign_stays_idle", 32'({req_ready, busy, pend_valid}), 32'b100);
    req_valid = 1'b1; req_addr = 32'h4000_0001; req_rd = 5'd4; req_funct3 = 3'b101;
    @(negedge clk);
    req_valid = 1'b0;
    chk("misalign_pulse_lhu", 32'(misalign), 32'd1);
    we_seen = 0; ar_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (reg_we) we_seen++;
      if (m_axi.arvalid) ar_seen++;
      chk("misalign_one_cycle", 32'(misalign), 32'd0);
    end
    chk("misalign_no_ar", ar_seen, 0);
    chk("misalign_no_we", we_seen, 0);
    v = '{32'h4000_0006, 5'd9, 3'b001, 32'hBEEF_1234, 2'b00, 0, 0, 32'hFFFF_BEEF};
    run_load(v);

    // Reset while waiting in R: everything clears, no write follows.
    req_valid = 1'b1; req_addr = 32'h4000_0020; req_rd = 5'd14; req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    m_axi.arready = 1'b1;
    @(negedge clk);
    m_axi.arready = 1'b0;
    chk("rst_seq_in_r", 32'(m_axi.rready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_mid_r");
    @(negedge clk);
    rst_n = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (reg_we) we_seen++;
    end
    chk("reset_no_we", we_seen, 0);
    chk("reset_idle_busy", 32'(busy), 32'd0);
    v = '{32'h4000_0024, 5'd15, 3'b100, 32'h0000_7F00, 2'b00, 1, 1, 32'h0000_007F};
    v.addr = 32'h4000_0025;
    run_load(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_load_wb_unit.md
Name: axi_load_wb_unit

Overview:
- Completes CPU loads that target the AXI-mapped peripheral space, e.g. H.264 encoder status and result registers.
- Accepts one load request from the MA stage and runs a single AXI4-Lite read on the master AR/R channels.
- Returns the extended result through the register file's secondary write port (m_axi_reg_we/m_axi_addr_d/m_axi_data_d); it is the driver of that port.
- Exports the pending destination register so the hazard unit can stall ID readers until writeback.

Parameters:
- ADDR_W, 32, width of m_axi_araddr_o.
- ARPROT, 3'b000, constant value driven on m_axi_arprot_o.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  MA-stage AXI load request
- req_ready_o  out  1  unit can accept a request (state IDLE)
- req_addr_i  in  32  byte address of the load
- req_rd_i  in  5  destination register
- req_funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- m_axi_araddr_o  out  ADDR_W  word-aligned read address
- m_axi_arprot_o  out  3  = ARPROT
- m_axi_arvalid_o  out  1  AR valid
- m_axi_arready_i  in  1  AR ready
- m_axi_rdata_i  in  32  read data
- m_axi_rresp_i  in  2  read response
- m_axi_rvalid_i  in  1  R valid
- m_axi_rready_o  out  1  R ready
- m_axi_reg_we_o  out  1  register-file secondary write enable, one-cycle pulse
- m_axi_addr_d_o  out  5  register-file write address
- m_axi_data_d_o  out  32  register-file write data
- pend_valid_o  out  1  a load is in flight and its rd is not yet written
- pend_rd_o  out  5  rd of the in-flight load
- busy_o  out  1  state != IDLE
- err_o  out  1  one-cycle pulse: RRESP != OKAY
- misalign_o  out  1  one-cycle pulse: misaligned request rejected

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0, except req_ready_o=1 after reset is released.
  - Internal address, rd, funct3 and data registers cleared.
- Reset mid-transaction: the transaction is abandoned and no register write occurs. The AXI slave shares the same reset, so no R beat is expected afterwards.
- FSM states: IDLE, AR, R, WB.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: capture addr, rd, funct3.
  - Misalignment check on the capture cycle:
    - LH/LHU with addr[0]=1 is misaligned.
    - LW with addr[1:0]!=0 is misaligned.
    - On misalignment: pulse misalign_o next cycle, stay IDLE, no AXI activity, no write.
  - Otherwise go to AR.
- AR:
  - m_axi_arvalid_o=1; m_axi_araddr_o={addr[ADDR_W-1:2],2'b00}.
  - araddr and arvalid stay stable until arready.
  - On arvalid&arready, go to R; arvalid drops the next cycle.
- R:
  - m_axi_rready_o=1.
  - On rvalid, capture rdata and rresp, go to WB.
  - rready is never asserted outside R.
- WB: one cycle, then IDLE.
  - m_axi_reg_we_o = (rd!=0).
  - m_axi_addr_d_o = rd.
  - m_axi_data_d_o = extended data.
  - If rresp!=2'b00: data forced to 0, write still performed when rd!=0, err_o=1 in the same cycle.
- Extension (lane = addr[1:0]; byte = rdata[8*lane+7:8*lane]; half = rdata[16*addr[1]+15:16*addr[1]]):
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend half.
  - LHU: zero-extend half.
  - LW: rdata unchanged.
  - Unsupported funct3 is treated as LW.
- Outside WB, m_axi_addr_d_o and m_axi_data_d_o hold 0.
- pend_valid_o=1 in AR, R and WB; pend_rd_o = captured rd (0 when idle). pend_valid_o is 0 if rd=0.
- Latency with arready and rvalid both first asserted in the cycle after entering AR/R:
  - accept on cycle 0, arvalid on cycle 1, rready on cycle 2, reg_we on cycle 3.
  - Minimum 3 cycles from accept to write.
  - Back-to-back request accepted on cycle 4.
- Requests arriving while busy are not accepted. MA must hold req_valid_i and the request fields until req_ready_o.
- Contract: the hazard unit stalls any ID instruction reading pend_rd_o while pend_valid_o=1, and stalls pipeline WB to the same rd during WB. This unit does no write arbitration.
- Simultaneous arvalid&arready in the same cycle state AR is entered is impossible: arvalid is registered.

Decomposition:
- Shared package holds:
  - load funct3 encodings (LB/LH/LW/LBU/LHU);
  - AXI RRESP constants (OKAY=2'b00, SLVERR=2'b10);
  - FSM state encoding.
- One sub-module, load_extend: purely combinational lane select and sign/zero extension (inputs rdata, addr[1:0], funct3).

Test Plan:
1. LW addr 0x4000_0008 rd=5; slave ready immediately, rdata=0xDEADBEEF, OKAY -> araddr=0x4000_0008; reg_we pulse on cycle 3, addr_d=5, data_d=0xDEADBEEF; pend_valid cycles 1-3 with pend_rd=5.
2. LB addr 0x4000_0003, rdata=0x80FF_0000 -> data_d=0xFFFF_FF80. LBU, same address and data -> 0x0000_0080. LHU addr 0x…02 -> 0x0000_80FF.
3. arready delayed 4 cycles, rvalid delayed 3 cycles -> araddr and arvalid stable throughout; rready high only in R; exactly one reg_we pulse; req_ready_o=0 until IDLE.
4. RRESP=SLVERR, rd=7 -> err_o and reg_we in the same cycle, data_d=0. With rd=0: err_o pulses, reg_we stays 0.
5. LW addr 0x…06 -> misalign_o pulse; arvalid never asserts; no write. A following valid LH at 0x…06 completes normally.
6. rst_n low while in R -> all outputs 0 immediately; after release, no reg_we pulse and a new request is accepted.
